// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: splits instruction fields, reads the 4x16 register file
// with same-cycle writeback bypass, and inserts a single bubble on load-use hazards.
module operand_fetch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  input  logic             flush,
  output logic [1:0]       rf_addr1,
  output logic [1:0]       rf_addr2,
  input  logic [WIDTH-1:0] rf_data1,
  input  logic [WIDTH-1:0] rf_data2,
  input  logic             wb_write,
  input  logic [1:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  output logic [3:0]       ex_op,
  output logic [5:0]       ex_funct,
  output logic [7:0]       ex_imm,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [1:0]       ex_dest,
  output logic             ex_wr,
  output logic             ex_load
);

  localparam logic [3:0] OP_ADI = 4'h4;
  localparam logic [3:0] OP_ORI = 4'h5;
  localparam logic [3:0] OP_LHI = 4'h6;
  localparam logic [3:0] OP_LWD = 4'h7;
  localparam logic [3:0] OP_SWD = 4'h8;
  localparam logic [3:0] OP_RTY = 4'hF;

  logic [3:0]       op_s;
  logic [1:0]       rs_s;
  logic [1:0]       rt_s;
  logic [1:0]       rd_s;
  logic [5:0]       funct_s;
  logic [7:0]       imm_s;
  logic             uses_rs_s;
  logic             uses_rt_s;
  logic             wr_s;
  logic             load_s;
  logic [1:0]       dest_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;
  logic             stall_s;

  assign op_s    = in_instr[15:12];
  assign rs_s    = in_instr[11:10];
  assign rt_s    = in_instr[9:8];
  assign rd_s    = in_instr[7:6];
  assign funct_s = in_instr[5:0];
  assign imm_s   = in_instr[7:0];

  assign rf_addr1 = rs_s;
  assign rf_addr2 = rt_s;

  // Field decode: which source registers are read, and what gets written back.
  always_comb begin
    uses_rs_s = 1'b0;
    uses_rt_s = 1'b0;
    wr_s      = 1'b0;
    load_s    = 1'b0;
    dest_s    = rt_s;
    case (op_s)
      OP_RTY: begin
        dest_s    = rd_s;
        wr_s      = (funct_s <= 6'd7);
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
      end
      OP_ADI, OP_ORI: begin
        wr_s      = 1'b1;
        uses_rs_s = 1'b1;
      end
      OP_LHI: begin
        wr_s = 1'b1;
      end
      OP_LWD: begin
        wr_s      = 1'b1;
        load_s    = 1'b1;
        uses_rs_s = 1'b1;
      end
      OP_SWD, 4'h0, 4'h1, 4'h2, 4'h3: begin
        uses_rs_s = 1'b1;
        uses_rt_s = 1'b1;
      end
      default: begin
        uses_rs_s = 1'b0;
        uses_rt_s = 1'b0;
      end
    endcase
  end

  // The register file commits on the same edge we capture, so forward writeback data.
  always_comb begin
    if (wb_write && (wb_addr == rs_s)) begin
      opa_s = wb_data;
    end else begin
      opa_s = rf_data1;
    end
    if (wb_write && (wb_addr == rt_s)) begin
      opb_s = wb_data;
    end else begin
      opb_s = rf_data2;
    end
  end

  // Load-use hazard against the instruction currently held in ID/EX.
  always_comb begin
    if (in_valid && ex_valid && ex_load && ex_wr) begin
      stall_s = (uses_rs_s && (ex_dest == rs_s)) || (uses_rt_s && (ex_dest == rt_s));
    end else begin
      stall_s = 1'b0;
    end
  end

  assign in_ready = ~stall_s;

  // ID/EX pipeline register; bubbles also clear wr/load so a hazard cannot repeat.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_op    <= 4'h0;
      ex_funct <= 6'h00;
      ex_imm   <= 8'h00;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_dest  <= 2'd0;
      ex_wr    <= 1'b0;
      ex_load  <= 1'b0;
    end else if (flush || stall_s) begin
      ex_valid <= 1'b0;
      ex_wr    <= 1'b0;
      ex_load  <= 1'b0;
    end else begin
      ex_valid <= in_valid;
      ex_op    <= op_s;
      ex_funct <= funct_s;
      ex_imm   <= imm_s;
      ex_a     <= opa_s;
      ex_b     <= opb_s;
      ex_dest  <= dest_s;
      ex_wr    <= wr_s;
      ex_load  <= load_s;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized self-checking bench for operand_fetch against a register-set level reference model.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic [1:0]  rf_addr1;
  logic [1:0]  rf_addr2;
  logic [15:0] rf_data1;
  logic [15:0] rf_data2;
  logic        wb_write;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [5:0]  ex_funct;
  logic [7:0]  ex_imm;
  logic [15:0] ex_a;
  logic [15:0] ex_b;
  logic [1:0]  ex_dest;
  logic        ex_wr;
  logic        ex_load;

  logic [15:0] rf [4];
  int total = 0;
  int bad = 0;

  // Reference model of the ID/EX contents
  logic        m_valid = 1'b0;
  logic [3:0]  m_op = 4'h0;
  logic [5:0]  m_funct = 6'h00;
  logic [7:0]  m_imm = 8'h00;
  logic [15:0] m_a = 16'h0000;
  logic [15:0] m_b = 16'h0000;
  logic [1:0]  m_dest = 2'd0;
  logic        m_wr = 1'b0;
  logic        m_load = 1'b0;
  logic        m_zero = 1'b0;
  logic        last_stall = 1'b0;

  operand_fetch #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1),
    .rf_data2(rf_data2), .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_funct(ex_funct), .ex_imm(ex_imm), .ex_a(ex_a),
    .ex_b(ex_b), .ex_dest(ex_dest), .ex_wr(ex_wr), .ex_load(ex_load)
  );

  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Set of registers an instruction reads, as a 4-bit membership mask.
  function automatic logic [3:0] reads(input logic [15:0] ins);
    logic [3:0] m;
    m = 4'b0000;
    case (ins[15:12])
      4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h8: begin
        m[ins[11:10]] = 1'b1;
        m[ins[9:8]] = 1'b1;
      end
      4'h4, 4'h5, 4'h7: m[ins[11:10]] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic writes(input logic [15:0] ins);
    return ((ins[15:12] == 4'hF) && (ins[5:0] < 6'd8)) ||
           ((ins[15:12] >= 4'h4) && (ins[15:12] <= 4'h7));
  endfunction

  task automatic cycle(input logic v, input logic [15:0] ins, input logic fl,
                       input logic ww, input logic [1:0] wa, input logic [15:0] wd,
                       input logic rst);
    logic        stall;
    logic [15:0] rfn [4];
    in_valid = v; in_instr = ins; flush = fl;
    wb_write = ww; wb_addr = wa; wb_data = wd; reset = rst;
    #1;
    stall = v && m_valid && m_load && m_wr && reads(ins)[m_dest];
    check("in_ready", {31'd0, in_ready}, {31'd0, ~stall});
    check("rf_addr", {28'd0, rf_addr1, rf_addr2}, {28'd0, ins[11:10], ins[9:8]});
    // Register contents as they will stand once this cycle's writeback commits
    for (int i = 0; i < 4; i++) rfn[i] = rf[i];
    if (ww) rfn[wa] = wd;
    m_zero = 1'b0;
    if (rst) begin
      m_valid = 1'b0; m_op = 4'h0; m_funct = 6'h00; m_imm = 8'h00; m_a = 16'h0000;
      m_b = 16'h0000; m_dest = 2'd0; m_wr = 1'b0; m_load = 1'b0; m_zero = 1'b1;
    end else if (fl || stall || !v) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_op = ins[15:12]; m_funct = ins[5:0]; m_imm = ins[7:0];
      m_a = rfn[ins[11:10]]; m_b = rfn[ins[9:8]];
      m_dest = (ins[15:12] == 4'hF) ? ins[7:6] : ins[9:8];
      m_wr = writes(ins);
      m_load = (ins[15:12] == 4'h7);
    end
    last_stall = stall;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rf[i] = rfn[i];
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    if (m_zero) begin
      check("rst_fields", {ex_op, ex_funct, ex_imm, ex_dest, ex_wr, ex_load, 10'd0}, 32'd0);
      check("rst_ab", {ex_a, ex_b}, 32'd0);
    end else if (m_valid) begin
      check("ex_ctl", {12'd0, ex_op, ex_funct, ex_imm, ex_wr, ex_load},
                      {12'd0, m_op, m_funct, m_imm, m_wr, m_load});
      check("ex_ab", {ex_a, ex_b}, {m_a, m_b});
      if (m_wr) check("ex_dest", {30'd0, ex_dest}, {30'd0, m_dest});
    end
  endtask

  function automatic logic [15:0] rtype(input logic [1:0] rs, input logic [1:0] rt,
                                        input logic [1:0] rd, input logic [5:0] fn);
    return {4'hF, rs, rt, rd, fn};
  endfunction

  initial begin
    logic        v;
    logic [15:0] ins;
    logic [3:0]  ops [13];
    ops = '{4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h4, 4'h5, 4'h6, 4'h8, 4'h0, 4'h2, 4'h9, 4'hC};
    reset = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; flush = 1'b0;
    wb_write = 1'b0; wb_addr = 2'd0; wb_data = 16'h0000;
    rf[0] = 16'h0000; rf[1] = 16'd5; rf[2] = 16'd7; rf[3] = 16'h0000;
    @(posedge clk);
    #1;

    // Reset, then a plain ADD r3 = r1 + r2
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1);
    cycle(1'b1, rtype(2'd1, 2'd2, 2'd3, 6'd0), 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    check("add_a", {16'd0, ex_a}, 32'd5);
    check("add_b", {16'd0, ex_b}, 32'd7);
    check("add_dest", {30'd0, ex_dest}, 32'd3);

    // Writeback bypass on rt, then on rs
    rf[2] = 16'h0000;
    cycle(1'b1, rtype(2'd0, 2'd2, 2'd1, 6'd0), 1'b0, 1'b1, 2'd2, 16'h00AA, 1'b0);
    check("byp_b", {16'd0, ex_b}, 32'h00AA);
    cycle(1'b1, rtype(2'd1, 2'd2, 2'd1, 6'd0), 1'b0, 1'b1, 2'd1, 16'h0055, 1'b0);
    check("byp_a", {16'd0, ex_a}, 32'h0055);

    // Load-use: one bubble, then the ADD picks up the load's writeback
    cycle(1'b1, {4'h7, 2'd0, 2'd1, 8'h04}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, rtype(2'd1, 2'd2, 2'd3, 6'd0), 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    check("lu_stall", {31'd0, last_stall}, 32'd1);
    cycle(1'b1, rtype(2'd1, 2'd2, 2'd3, 6'd0), 1'b0, 1'b1, 2'd1, 16'h1234, 1'b0);
    check("lu_fwd", {16'd0, ex_a}, 32'h1234);

    // No false stall after a load for LHI and JMP
    cycle(1'b1, {4'h7, 2'd0, 2'd1, 8'h04}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, {4'h6, 2'd1, 2'd1, 8'h77}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, {4'h7, 2'd0, 2'd1, 8'h04}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, {4'h9, 2'd1, 2'd1, 8'h44}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);

    // Flush while a load-use stall is pending; held ADD issues afterwards
    cycle(1'b1, {4'h7, 2'd0, 2'd2, 8'h08}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, rtype(2'd0, 2'd2, 2'd1, 6'd1), 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, rtype(2'd0, 2'd2, 2'd1, 6'd1), 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);

    // Reset during a stall cycle, then normal issue
    cycle(1'b1, {4'h7, 2'd0, 2'd3, 8'h0C}, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
    cycle(1'b1, rtype(2'd3, 2'd0, 2'd2, 6'd2), 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1);
    cycle(1'b1, rtype(2'd3, 2'd0, 2'd2, 6'd2), 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);

    // Random traffic; fetch holds its instruction whenever it was stalled
    v = 1'b1;
    ins = 16'h0000;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        v = ($urandom_range(0, 7) != 0);
        ins = 16'($urandom);
        ins[15:12] = ops[$urandom_range(0, 12)];
      end
      cycle(v, ins, ($urandom_range(0, 15) == 0), 1'($urandom), 2'($urandom),
            16'($urandom), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Decode/operand-fetch stage that sits directly upstream of the 4×16-bit register file.
- Takes one instruction per cycle from fetch and splits out its fields.
- Drives the register-file read addresses, bypasses same-cycle writeback data, and inserts a one-cycle bubble on load-use hazards.
- Registers decoded operands into an ID/EX pipeline register consumed by the execute stage.

## Interface
- WIDTH, 16, data/instruction width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- in_valid  in  1  fetch presents a valid instruction
- in_instr  in  WIDTH  instruction: op[15:12], rs[11:10], rt[9:8], rd[7:6], funct[5:0], imm[7:0]
- in_ready  out  1  combinational; 0 while stalling, and fetch must hold in_instr
- flush  in  1  squash the current input and the ID/EX contents (branch redirect)
- rf_addr1, rf_addr2  out  2  combinational register-file read addresses: rs and rt
- rf_data1, rf_data2  in  WIDTH  combinational register-file read data
- wb_write, wb_addr[1:0], wb_data[WIDTH-1:0]  in  writeback port; the same signals feed the register-file write port
- ex_valid, ex_op[3:0], ex_funct[5:0], ex_imm[7:0], ex_a, ex_b (WIDTH), ex_dest[1:0], ex_wr, ex_load  out  ID/EX register

## Operation
Decode, combinational on in_instr:
- R-type (op=4'hF):
  - dest=rd
  - wr=1 iff funct ≤ 6'd7
  - uses rs and rt
- op 4–6 (ADI/ORI/LHI):
  - dest=rt, wr=1
  - uses rs, except op 6, which uses nothing
- op 7 (LWD):
  - dest=rt, wr=1, load=1
  - uses rs
- op 8 (SWD): uses rs and rt; wr=0.
- op 0–3 (branches): use rs and rt; wr=0.
- op 9/10 (jumps): use nothing; wr=0.
- All other ops: wr=0; treated as using nothing.
- dest is don't-care when wr=0, but is registered as decoded.

Operand bypass:
- ex_a source = wb_data if wb_write && wb_addr==rs, else rf_data1.
- ex_b source = wb_data if wb_write && wb_addr==rt, else rf_data2.
- The bypass is required because the register file commits on the same edge the ID/EX register captures.

Hazard:
- stall = in_valid && ex_valid && ex_load && ex_wr && ((uses_rs && ex_dest==rs) || (uses_rt && ex_dest==rt)).
- in_ready = ~stall.

ID/EX update, in priority order, each clock:
1. reset: every ex_* output ← 0.
2. flush: ex_valid←0; the other ex_* fields may update but are don't-care.
3. stall: ex_valid←0 (bubble); fetch holds the instruction; the instruction is re-decoded next cycle.
4. Otherwise: ex_valid←in_valid, and all fields load from the decode and the bypassed operands.

Other rules:
- When in_valid=0, ex_valid←0 and the other fields are don't-care.
- flush overrides stall; in_ready still reflects stall.
- No arithmetic in this block. imm passes unmodified; sign/zero extension belongs to execute.

## Timing
- Latency: 1 cycle from in_valid/in_instr accept to ex_* valid.
- Throughput: one instruction per cycle, except a load-use pair costs exactly one bubble cycle.
- Stall lasts exactly 1 cycle: after the bubble, ex_load=0, so the hazard condition cannot repeat.
- The stalled instruction issues on the next cycle. Its operand comes from the wb bypass if the load is then in writeback, or from the register file afterwards.
- Reset mid-stall: the next cycle has ex_valid=0 and in_ready=1.
- rf_addr1/2 and in_ready are combinational from in_instr and the ID/EX state, with no register stage.

## Test plan
- Reset → all ex_* = 0, in_ready=1. Then issue ADD (op F, rs=1, rt=2, rd=3, funct 0) with RF r1=5, r2=7 → next cycle: ex_valid=1, ex_a=5, ex_b=7, ex_dest=3, ex_wr=1.
- Writeback bypass: wb_write=1, wb_addr=2, wb_data=16'h00AA in the same cycle an instruction reads rt=2 with RF r2=0 → ex_b=16'h00AA. Repeat with wb_addr=1 → ex_a bypassed, ex_b=RF value.
- Load-use: LWD rt=1 followed by ADD rs=1 → in_ready=0 for one cycle, one ex_valid=0 bubble, then ADD issues with ex_a=wb_data from the load's writeback.
- No false stall: LWD rt=1 followed by LHI (rs field=1) or JMP → in_ready stays 1, no bubble.
- Flush: assert flush while an instruction is in ID/EX and a load-use stall is pending → ex_valid=0 next cycle; the held instruction issues afterward.
- Reset asserted during a stall cycle → the next cycle has all ex_*=0 and in_ready=1; normal issue resumes on the following cycle.
